// File: rtl/gobang_pkg.sv
// Shared definitions for the gobang move controller: point encoding,
// controller FSM states and the default board edge length.
package gobang_pkg;

    localparam int DEFAULT_N = 15;

    // Two-bit state of one board point.
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_WHITE = 2'b01;
    localparam logic [1:0] CELL_BLACK = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITE,
        COMMIT
    } move_state_t;

    // Stone colour of the player to move: turn 0 is black, turn 1 is white.
    function automatic logic [1:0] stone_of(input logic turn);
        return turn ? CELL_WHITE : CELL_BLACK;
    endfunction

endpackage

// File: rtl/move_controller_if.sv
// Player/board-side signal bundle of the move controller. The master side
// issues cursor steps and place requests and presents the board; the slave
// side is the controller itself.
interface move_controller_if import gobang_pkg::*; #(
    parameter int N  = DEFAULT_N,
    parameter int CW = 4
);
    logic                 move_up;
    logic                 move_down;
    logic                 move_left;
    logic                 move_right;
    logic                 place;
    logic                 game_over;
    logic [2*N*N-1:0]     board_q;

    logic [CW-1:0]        cursor_x;
    logic [CW-1:0]        cursor_y;
    logic                 turn;
    logic [1:0]           point_d;
    logic [N*N-1:0]       point_we;
    logic [8:0]           move_count;
    logic                 board_full;
    logic                 placed;
    logic                 reject;

    modport master (
        output move_up, move_down, move_left, move_right, place, game_over, board_q,
        input  cursor_x, cursor_y, turn, point_d, point_we, move_count,
               board_full, placed, reject
    );

    modport slave (
        input  move_up, move_down, move_left, move_right, place, game_over, board_q,
        output cursor_x, cursor_y, turn, point_d, point_we, move_count,
               board_full, placed, reject
    );
endinterface

// File: rtl/cursor_axis.sv
// One cursor coordinate: a modulo-N up/down counter. Simultaneous inc and
// dec cancel; the counter only moves while en is high.
module cursor_axis #(
    parameter int N  = 15,
    parameter int CW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] pos
);
    localparam logic [CW-1:0] MAX = CW'(N - 1);
    localparam logic [CW-1:0] MID = CW'(N / 2);
    localparam logic [CW-1:0] ONE = CW'(1);

    // Step the coordinate with wrap-around at both ends of the board.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            pos <= MID;
        end else if (en && (inc ^ dec)) begin
            if (inc) begin
                pos <= (pos == MAX) ? '0 : pos + ONE;
            end else begin
                pos <= (pos == '0) ? MAX : pos - ONE;
            end
        end
    end
endmodule

// File: rtl/move_controller.sv
// Turn and placement controller. Owns the cursor and whose turn it is,
// checks the target point of a place request against the board and issues
// a one-cycle write of the current stone when the point is empty.
module move_controller import gobang_pkg::*; #(
    parameter int N  = DEFAULT_N,
    parameter int CW = 4
) (
    input logic               clock,
    input logic               reset,
    move_controller_if.slave  bus
);
    localparam int         NP         = N * N;
    localparam int         IW         = (NP > 1) ? $clog2(NP) : 1;
    localparam logic [8:0] FULL_COUNT = 9'(NP);

    move_state_t    state;
    move_state_t    next_state;

    logic [CW-1:0]  cur_x;
    logic [CW-1:0]  cur_y;
    logic [IW-1:0]  cur_idx;
    logic [IW-1:0]  idx_q;
    logic           colour_q;
    logic [1:0]     target_cell;

    logic           accept;
    logic           refuse;
    logic           step_en;

    // Registered outputs and their next values.
    logic           turn_q,   turn_nxt;
    logic [8:0]     count_q,  count_nxt;
    logic           full_q,   full_nxt;
    logic           placed_q, placed_nxt;
    logic           reject_q, reject_nxt;
    logic [1:0]     d_q,      d_nxt;
    logic [NP-1:0]  we_q,     we_nxt;

    assign cur_idx     = IW'(int'(cur_y) * N + int'(cur_x));
    assign target_cell = bus.board_q[{idx_q, 1'b0} +: 2];

    // A request in IDLE is either taken or refused immediately; requests
    // arriving while a move is in flight are ignored.
    assign accept  = (state == IDLE) && bus.place && !bus.game_over && !full_q;
    assign refuse  = (state == IDLE) && bus.place && (bus.game_over || full_q);
    assign step_en = (state == IDLE) && !accept;

    cursor_axis #(.N(N), .CW(CW)) u_axis_x (
        .clock (clock),
        .reset (reset),
        .en    (step_en),
        .inc   (bus.move_right),
        .dec   (bus.move_left),
        .pos   (cur_x)
    );

    cursor_axis #(.N(N), .CW(CW)) u_axis_y (
        .clock (clock),
        .reset (reset),
        .en    (step_en),
        .inc   (bus.move_down),
        .dec   (bus.move_up),
        .pos   (cur_y)
    );

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = CHECK;
            CHECK:   next_state = (target_cell == CELL_EMPTY) ? WRITE : IDLE;
            WRITE:   next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the target point and the mover's colour when a request is taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q    <= '0;
            colour_q <= 1'b0;
        end else if (accept) begin
            idx_q    <= cur_idx;
            colour_q <= turn_q;
        end
    end

    // Output values for the coming cycle, decoded from the state being entered
    // so that every output comes straight from a flop.
    always_comb begin
        turn_nxt   = turn_q;
        count_nxt  = count_q;
        placed_nxt = 1'b0;
        reject_nxt = 1'b0;
        we_nxt     = '0;
        if (refuse) begin
            reject_nxt = 1'b1;
        end
        if ((state == CHECK) && (target_cell != CELL_EMPTY)) begin
            reject_nxt = 1'b1;
        end
        if (next_state == WRITE) begin
            we_nxt[idx_q] = 1'b1;
        end
        if (next_state == COMMIT) begin
            turn_nxt   = ~turn_q;
            count_nxt  = count_q + 9'd1;
            placed_nxt = 1'b1;
        end
        d_nxt    = (next_state == WRITE) ? stone_of(colour_q) : stone_of(turn_nxt);
        full_nxt = (count_nxt == FULL_COUNT);
    end

    // Output registers; reset drops the write enable at once, aborting a move.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            turn_q   <= 1'b0;
            count_q  <= '0;
            full_q   <= 1'b0;
            placed_q <= 1'b0;
            reject_q <= 1'b0;
            d_q      <= CELL_BLACK;
            we_q     <= '0;
        end else begin
            turn_q   <= turn_nxt;
            count_q  <= count_nxt;
            full_q   <= full_nxt;
            placed_q <= placed_nxt;
            reject_q <= reject_nxt;
            d_q      <= d_nxt;
            we_q     <= we_nxt;
        end
    end

    assign bus.cursor_x   = cur_x;
    assign bus.cursor_y   = cur_y;
    assign bus.turn       = turn_q;
    assign bus.point_d    = d_q;
    assign bus.point_we   = we_q;
    assign bus.move_count = count_q;
    assign bus.board_full = full_q;
    assign bus.placed     = placed_q;
    assign bus.reject     = reject_q;
endmodule
